// File: rtl/mux_slot_pkg.sv
// Shared types and widths for the multiplexed project-slot driver.
package mux_slot_pkg;

  localparam int IW_W  = 18;
  localparam int OW_W  = 24;
  localparam int CNT_W = 16;
  localparam int TMR_W = 8;

  typedef enum logic [1:0] {
    OP_SET_IN = 2'd0,
    OP_RESET  = 2'd1,
    OP_STEP   = 2'd2,
    OP_ENABLE = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/mux_phase_timer.sv
// Phase timer: a down-counter reloaded on each phase entry.
// expire is high during the last system clock of a phase.
module mux_phase_timer
  import mux_slot_pkg::*;
#(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam logic [TMR_W-1:0] RELOAD = TMR_W'(HALF_PERIOD - 1);

  logic [TMR_W-1:0] timer;

  // Reload on phase entry, otherwise count down to zero and hold there.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (load) begin
      timer <= RELOAD;
    end else if (timer != '0) begin
      timer <= timer - TMR_W'(1);
    end
  end

  assign expire = (timer == '0);

endmodule

// File: rtl/mux_slot_driver.sv
// Drives one multiplexed project slot: applies inputs, clocks the project
// for a commanded number of cycles, and returns a snapshot of its outputs.
//
// state | meaning
// IDLE  | waiting for a command (cmd_ready = 1)
// HIGH  | project clock high for HALF_PERIOD system clocks
// LOW   | project clock low for HALF_PERIOD system clocks
// RESP  | snapshot of ow held on rsp_data until rsp_ready
module mux_slot_driver
  import mux_slot_pkg::*;
#(
  parameter int HALF_PERIOD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [15:0]       cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OW_W-1:0]   rsp_data,
  output logic              ena,
  output logic [IW_W-1:0]   iw,
  input  logic [OW_W-1:0]   ow
);

  state_e            state;
  state_e            state_next;
  op_e               op_q;
  logic [CNT_W-1:0]  count;
  logic [7:0]        ui_in;
  logic [7:0]        uio_in;
  logic              rst_n_q;
  logic              load;
  logic              expire;
  logic              accept;
  logic              enter_resp;

  mux_phase_timer #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          unique case (op_e'(cmd_op))
            OP_SET_IN: state_next = ST_RESP;
            OP_ENABLE: state_next = ST_RESP;
            OP_STEP:   state_next = (cmd_data == 16'd0) ? ST_RESP : ST_HIGH;
            OP_RESET:  state_next = ST_HIGH;
          endcase
        end
      end
      ST_HIGH: begin
        if (expire) state_next = ST_LOW;
      end
      ST_LOW: begin
        if (expire) state_next = (count <= CNT_W'(1)) ? ST_RESP : ST_HIGH;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = ST_IDLE;
      end
    endcase
  end

  assign accept     = cmd_valid & cmd_ready;
  assign load       = (state_next != state) &&
                      ((state_next == ST_HIGH) || (state_next == ST_LOW));
  assign enter_resp = (state_next == ST_RESP) && (state != ST_RESP);

  // Slot input registers, cycle count and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_SET_IN;
      count    <= '0;
      ui_in    <= '0;
      uio_in   <= '0;
      rst_n_q  <= 1'b0;
      ena      <= 1'b0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        op_q <= op_e'(cmd_op);
        unique case (op_e'(cmd_op))
          OP_SET_IN: begin
            ui_in  <= cmd_data[7:0];
            uio_in <= cmd_data[15:8];
            count  <= '0;
          end
          OP_ENABLE: ena <= cmd_data[0];
          OP_STEP:   count <= cmd_data;
          OP_RESET: begin
            rst_n_q <= 1'b0;
            count   <= (cmd_data[7:0] == 8'd0) ? CNT_W'(1) : {8'd0, cmd_data[7:0]};
          end
        endcase
      end
      if ((state == ST_LOW) && expire) begin
        count <= count - CNT_W'(1);
      end
      if (enter_resp) begin
        rsp_data <= ow;
        // Only a RESET run reaches RESP from LOW with op_q == OP_RESET.
        if ((state == ST_LOW) && (op_q == OP_RESET)) rst_n_q <= 1'b1;
      end
    end
  end

  assign iw = {uio_in, ui_in, rst_n_q, (state == ST_HIGH)};

endmodule

// File: tb/tb_mux_slot_driver.sv
// Randomised scoreboard bench for mux_slot_driver.
module tb_mux_slot_driver;

  localparam int HP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_data = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [23:0] rsp_data;
  logic        ena;
  logic [17:0] iw;
  logic [23:0] ow = 24'd0;

  int checks = 0;
  int failures = 0;
  int edge_total = 0;
  logic [23:0] exp_q[$];

  // Reference state of the slot inputs as the bench believes them to be.
  logic [7:0] m_ui = 8'd0;
  logic [7:0] m_uio = 8'd0;
  logic       m_ena = 1'b0;
  logic       m_rstn = 1'b0;

  mux_slot_driver #(.HALF_PERIOD(HP)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ena       (ena),
    .iw        (iw),
    .ow        (ow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [17:0] model_iw();
    return {m_uio, m_ui, m_rstn, 1'b0};
  endfunction

  // Monitor: compares each handshaken response against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual=%0h required=none", rsp_data);
        end else begin
          check("rsp_data", {8'd0, rsp_data}, {8'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Counts rising edges of the project clock.
  initial begin
    forever begin
      @(posedge iw[0]);
      edge_total++;
    end
  end

  task automatic model_reset();
    m_ui = 8'd0;
    m_uio = 8'd0;
    m_ena = 1'b0;
    m_rstn = 1'b0;
    exp_q.delete();
  endtask

  // Issue one command, check latency / clocking / hold, then consume response.
  task automatic run_cmd(input logic [1:0] op, input logic [15:0] data, input int ready_delay,
                         input logic [23:0] ow_a, input logic [23:0] ow_b);
    int n, lat, k, edges0;
    logic bad_hold, bad_rstn, bad_resp;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    case (op)
      2'd2:    n = int'(data);
      2'd1:    n = (data[7:0] == 8'd0) ? 1 : int'(data[7:0]);
      default: n = 0;
    endcase
    lat = 1 + 2 * HP * n;
    ow = (lat == 1) ? ow_b : ow_a;
    cmd_op = op;
    cmd_data = data;
    cmd_valid = 1'b1;
    edges0 = edge_total;
    exp_q.push_back(ow_b);
    if (op == 2'd0) begin
      m_ui = data[7:0];
      m_uio = data[15:8];
    end
    if (op == 2'd3) m_ena = data[0];
    bad_hold = 1'b0;
    bad_rstn = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1;
    while (!rsp_valid && k < lat + 20) begin
      if (iw[17:2] !== {m_uio, m_ui} || ena !== m_ena) bad_hold = 1'b1;
      if (op == 2'd1 && iw[1] !== 1'b0) bad_rstn = 1'b1;
      if (k == lat - 1) ow = ow_b;
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'(lat));
    if (!rsp_valid) begin
      void'(exp_q.pop_back());
      return;
    end
    ow = ~ow_b;
    check("clk_edges", 32'(edge_total - edges0), 32'(n));
    check("clk_low_in_resp", 32'(iw[0]), 32'd0);
    if (n > 0) check("inputs_held", 32'(bad_hold), 32'd0);
    if (op == 2'd1) begin
      check("rst_n_low_during", 32'(bad_rstn), 32'd0);
      m_rstn = 1'b1;
      check("rst_n_after", 32'(iw[1]), 32'd1);
    end
    if (ready_delay > 0) begin
      bad_resp = 1'b0;
      repeat (ready_delay) begin
        @(negedge clk);
        if (rsp_data !== ow_b || rsp_valid !== 1'b1 || cmd_ready !== 1'b0) bad_resp = 1'b1;
      end
      check("resp_held", 32'(bad_resp), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_after_rsp", 32'(cmd_ready), 32'd1);
    check("iw", 32'(iw), 32'(model_iw()));
    check("ena", 32'(ena), 32'(m_ena));
  endtask

  initial begin
    int k;
    logic bad;
    logic [1:0] op;
    logic [15:0] data;

    // Reset state.
    ow = 24'($urandom);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_iw", 32'(iw), 32'd0);
    check("rst_ena", 32'(ena), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst = 1'b0;
    model_reset();

    // ENABLE 1 then SET_IN A55A.
    run_cmd(2'd3, 16'h0001, 0, 24'h0, 24'($urandom));
    check("ena_set", 32'(ena), 32'd1);
    run_cmd(2'd0, 16'hA55A, 0, 24'h0, 24'($urandom));
    check("iw_set_in", 32'(iw), 32'h29568);

    // RESET 2, and RESET whose low byte is 0 (one project clock).
    run_cmd(2'd1, 16'h0002, 0, 24'($urandom), 24'($urandom));
    run_cmd(2'd1, 16'hAB00, 0, 24'($urandom), 24'($urandom));

    // STEP 3 capturing 123456, then STEP 0.
    run_cmd(2'd2, 16'd3, 0, 24'h000000, 24'h123456);
    run_cmd(2'd2, 16'd0, 0, 24'($urandom), 24'($urandom));

    // Response held with rsp_ready low for 10 clocks.
    run_cmd(2'd2, 16'd1, 10, 24'($urandom), 24'($urandom));

    // rst asserted while the project clock is high.
    cmd_op = 2'd2;
    cmd_data = 16'd5;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (iw[0] !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mid_step_clk_high", 32'(iw[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("mid_rst_idle", 32'(cmd_ready), 32'd1);
    check("mid_rst_iw", 32'(iw[1:0]), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b1;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad = 1'b1;
    end
    rsp_ready = 1'b0;
    check("mid_rst_no_rsp", 32'(bad), 32'd0);

    // Randomised command stream.
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom_range(0, 3));
      case (op)
        2'd2:    data = 16'($urandom_range(0, 6));
        2'd1:    data = {8'($urandom), 8'($urandom_range(0, 4))};
        default: data = 16'($urandom);
      endcase
      run_cmd(op, data, $urandom_range(0, 3), 24'($urandom), 24'($urandom));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_slot_driver.md
MUX_SLOT_DRIVER -- requirements
Module: mux_slot_driver

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 2: system clocks per project-clock phase; legal range 1..255.
REQ-002 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port cmd_valid, input, 1: command offered.
REQ-005 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid & cmd_ready.
REQ-006 SHALL have port cmd_op, input, 2: 0 SET_IN, 1 RESET, 2 STEP, 3 ENABLE.
REQ-007 SHALL have port cmd_data, input, 16: operand.
REQ-008 SHALL have port rsp_valid, output, 1: response available.
REQ-009 SHALL have port rsp_ready, input, 1: response consumed when rsp_valid & rsp_ready.
REQ-010 SHALL have port rsp_data, output, 24: sampled slot outputs {uio_oe, uio_out, uo_out}.
REQ-011 SHALL have port ena, output, 1: slot enable.
REQ-012 SHALL have port iw, output, 18: slot inputs packed {uio_in[7:0], ui_in[7:0], rst_n, clk}.
REQ-013 SHALL have port ow, input, 24: slot outputs packed {uio_oe, uio_out, uo_out}.

Function
REQ-014 SHALL implement states IDLE, HIGH, LOW, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-015 SHALL apply SET_IN as follows: on accept, ui_in <= cmd_data[7:0] and uio_in <= cmd_data[15:8]; then IDLE->RESP with count 0.
REQ-016 SHALL apply ENABLE as follows: on accept, ena <= cmd_data[0]; then IDLE->RESP.
REQ-017 SHALL apply STEP as follows: on accept, load 16-bit count <= cmd_data; if count==0 go to RESP, else go to HIGH.
REQ-018 SHALL apply RESET as follows: on accept, rst_n <= 0 and count <= cmd_data[7:0], where 0 is treated as 1; go to HIGH; rst_n <= 1 on entry to RESP.
REQ-019 SHALL drive iw clk bit = 1 in HIGH and 0 in every other state.
REQ-020 SHALL keep HIGH and LOW each exactly HIGH_PERIOD... specifically, each phase SHALL last exactly HALF_PERIOD system clocks, measured by a phase timer reloaded on every state entry.
REQ-021 SHALL sequence phases as follows: HIGH expiry -> LOW; LOW expiry decrements count; count reaching 0 -> RESP, else -> HIGH.
REQ-022 SHALL capture ow into rsp_data in the same system clock as the transition into RESP, i.e. after the final LOW phase completes, with project clk already 0.
REQ-023 SHALL assert rsp_valid throughout RESP and hold rsp_data stable until the handshake; RESP->IDLE on rsp_ready.
REQ-024 SHALL not accept a new command while in RESP, even when rsp_ready is 1 in the same cycle; acceptance is possible from the next cycle.
REQ-025 SHALL hold ui_in, uio_in, and ena constant during HIGH/LOW.
REQ-026 SHALL give a STEP of N >= 1 a total latency from accept to rsp_valid of exactly 1 + 2*HALF_PERIOD*N system clocks.
REQ-027 SHALL treat count as an unsigned 16-bit value; 65535 is legal, and no wrap-around SHALL occur.

Reset
REQ-028 SHALL on rst set state = IDLE, iw = 0 (project rst_n held low, clk 0, ui_in = uio_in = 0), ena = 0, rsp_valid = 0, rsp_data = 0, count = 0, and timer = 0.
REQ-029 SHALL give rst priority over all activity: rst asserted mid-HIGH SHALL drive clk to 0 and rst_n to 0 on the next edge, and SHALL discard any pending response.
REQ-030 SHALL keep project rst_n low after rst until a RESET command completes.

Structure
REQ-031 SHALL place the opcode enum, state enum, and widths (IW_W = 18, OW_W = 24, CNT_W = 16) in shared package mux_slot_pkg.
REQ-032 SHALL implement the phase timer as sub-module mux_phase_timer (inputs load and HALF_PERIOD; output expire).

Verification
REQ-033 SHALL verify reset: after rst, cmd_ready=1, iw=18'h0, ena=0, rsp_valid=0.
REQ-034 SHALL verify ENABLE 1, then SET_IN 16'hA55A: ena=1, iw=18'h29568, and one response each.
REQ-035 SHALL verify RESET 2 at HALF_PERIOD=2: rst_n=0 across 2 project clocks (9 system clocks to rsp_valid), then rst_n=1.
REQ-036 SHALL verify STEP 3 with ow driven to 24'h123456 before the final LOW ends: rsp_valid at 13 clocks after accept, rsp_data=24'h123456, with exactly 3 clk rising edges on iw[0].
REQ-037 SHALL verify STEP 0: rsp_valid the clock after accept, no clk edges.
REQ-038 SHALL verify rsp_ready held low 10 clocks: rsp_data stable, cmd_ready=0; rst asserted mid-STEP: immediate IDLE, iw[1:0]=0, no response.
